// File: rtl/dlx_instr_loader_if.sv
// Command handshake and IRAM write bus shared by the DLX instruction loader and its neighbours.
// The loader takes the slave side; the stimulus/IRAM side takes master.
interface dlx_instr_loader_if #(
  parameter int unsigned ADDR_W = 6
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [5:0]        cmd_opcode;
  logic [4:0]        cmd_rs1;
  logic [4:0]        cmd_rs2;
  logic [4:0]        cmd_rd;
  logic [10:0]       cmd_func;
  logic [25:0]       cmd_imm;
  logic              cmd_last;
  logic              iram_we;
  logic              iram_ready;
  logic [ADDR_W-1:0] iram_addr;
  logic [31:0]       iram_wdata;

  modport master (
    output cmd_valid, cmd_opcode, cmd_rs1, cmd_rs2, cmd_rd, cmd_func, cmd_imm, cmd_last,
    input  cmd_ready,
    input  iram_we, iram_addr, iram_wdata,
    output iram_ready
  );

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_rs1, cmd_rs2, cmd_rd, cmd_func, cmd_imm, cmd_last,
    output cmd_ready,
    output iram_we, iram_addr, iram_wdata,
    input  iram_ready
  );
endinterface

// File: rtl/dlx_instr_loader.sv
// Packs DLX instruction fields into words, buffers them, writes them to IRAM, appends NOPs,
// then holds the DLX in reset for a fixed time before releasing it.
module dlx_instr_loader #(
  parameter int unsigned IRAM_DEPTH  = 64,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned PAD_NOPS    = 4,
  parameter int unsigned HOLD_CYCLES = 4,
  localparam int unsigned ADDR_W     = $clog2(IRAM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  dlx_instr_loader_if.slave bus,
  output logic              dlx_rst,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned WcW   = ADDR_W + 1;
  localparam int unsigned PadW  = $clog2(PAD_NOPS + 2);
  localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);
  localparam logic [31:0] NopWord = 32'h5400_0000;

  typedef enum logic [2:0] {StIdle, StLoad, StPad, StHold, StRun, StErr} state_e;

  state_e            state_q, state_d;
  logic [31:0]       fifo_mem [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   fifo_cnt_q, fifo_cnt_d;
  logic              last_seen_q, last_seen_d;
  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_data_q, out_data_d;
  logic [WcW-1:0]    word_count_q, wc_next;
  logic [PadW-1:0]   pad_left_q, pad_left_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic [31:0]       enc_word;
  logic              cmd_ready, push, pop, wr_done, slot_free, at_limit, fifo_empty, fifo_full;

  always_comb begin
    enc_word = {bus.cmd_opcode, bus.cmd_rs1, bus.cmd_rd, bus.cmd_imm[15:0]};
    if (bus.cmd_opcode == 6'h00) begin
      enc_word = {bus.cmd_opcode, bus.cmd_rs1, bus.cmd_rs2, bus.cmd_rd, bus.cmd_func};
    end else if (bus.cmd_opcode == 6'h02 || bus.cmd_opcode == 6'h03) begin
      enc_word = {bus.cmd_opcode, bus.cmd_imm};
    end
  end

  assign fifo_empty = (fifo_cnt_q == '0);
  assign fifo_full  = (fifo_cnt_q == CntW'(FIFO_DEPTH));
  assign cmd_ready  = (state_q == StLoad) && !fifo_full && !last_seen_q;
  assign push       = bus.cmd_valid && cmd_ready;
  assign wr_done    = out_valid_q && bus.iram_ready;
  assign slot_free  = !out_valid_q || wr_done;
  assign wc_next    = word_count_q + WcW'(wr_done);
  // A word loaded now would be addressed at wc_next; IRAM has no room for it there.
  assign at_limit   = (wc_next == WcW'(IRAM_DEPTH));
  assign fifo_cnt_d = fifo_cnt_q + CntW'(push) - CntW'(pop);

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    out_valid_d = out_valid_q && !wr_done;
    out_data_d  = out_data_q;
    pad_left_d  = pad_left_q;
    hold_d      = hold_q;
    last_seen_d = last_seen_q || (push && bus.cmd_last);
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StLoad;
          last_seen_d = 1'b0;
        end
      end
      StLoad: begin
        if (!fifo_empty && slot_free) begin
          if (at_limit) begin
            state_d = StErr;
          end else begin
            pop         = 1'b1;
            out_valid_d = 1'b1;
            out_data_d  = fifo_mem[rd_ptr_q];
          end
        end else if (last_seen_q && fifo_empty && slot_free) begin
          if (PAD_NOPS > 0) begin
            state_d    = StPad;
            pad_left_d = PadW'(PAD_NOPS);
          end else begin
            state_d = StHold;
            hold_d  = HoldW'(HOLD_CYCLES - 1);
          end
        end
      end
      StPad: begin
        if (slot_free) begin
          if (pad_left_q != '0) begin
            if (at_limit) begin
              state_d = StErr;
            end else begin
              out_valid_d = 1'b1;
              out_data_d  = NopWord;
              pad_left_d  = pad_left_q - PadW'(1);
            end
          end else begin
            state_d = StHold;
            hold_d  = HoldW'(HOLD_CYCLES - 1);
          end
        end
      end
      StHold: begin
        if (hold_q == '0) begin
          state_d = StRun;
        end else begin
          hold_d = hold_q - HoldW'(1);
        end
      end
      StRun, StErr: ;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= enc_word;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
      last_seen_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      word_count_q <= '0;
      pad_left_q   <= '0;
      hold_q       <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_q + PtrW'(push);
      rd_ptr_q     <= rd_ptr_q + PtrW'(pop);
      fifo_cnt_q   <= fifo_cnt_d;
      last_seen_q  <= last_seen_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      word_count_q <= wc_next;
      pad_left_q   <= pad_left_d;
      hold_q       <= hold_d;
    end
  end

  assign bus.cmd_ready  = cmd_ready;
  assign bus.iram_we    = out_valid_q;
  assign bus.iram_addr  = word_count_q[ADDR_W-1:0];
  assign bus.iram_wdata = out_data_q;
  assign dlx_rst        = (state_q == StRun);
  assign done           = (state_q == StRun);
  assign err            = (state_q == StErr);
  assign busy           = (state_q == StLoad) || (state_q == StPad) || (state_q == StHold);
  assign word_count     = word_count_q;
endmodule

// File: tb/tb_dlx_instr_loader.sv
// Randomised bench for dlx_instr_loader: programs are replayed through a field-level encoder
// model and the recorded IRAM writes, status outputs and reset-release timing are compared.
module tb_dlx_instr_loader;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PADS  = 2;
  localparam int unsigned HOLD  = 4;
  localparam logic [31:0] NOP   = 32'h5400_0000;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [10:0] func;
    logic [25:0] imm;
    logic        last;
  } cmd_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          dlx_rst, busy, done, err;
  logic [AW:0]   word_count;

  dlx_instr_loader_if #(.ADDR_W(AW)) bus ();

  dlx_instr_loader #(
    .IRAM_DEPTH (DEPTH),
    .FIFO_DEPTH (4),
    .PAD_NOPS   (PADS),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bus       (bus),
    .dlx_rst   (dlx_rst),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          last_wr_edge = 0;
  int          ready_mode   = 0;  // 0: always ready, 1: random, 2: stalled
  cmd_t        prog_q[$];
  cmd_t        acc_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_addr_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Drives iram_ready and logs every write that will complete on the coming posedge.
  always @(negedge clk) begin
    logic r;
    case (ready_mode)
      0:       r = 1'b1;
      1:       r = 1'($urandom_range(0, 1));
      default: r = 1'b0;
    endcase
    bus.iram_ready = r;
    if (rst && bus.iram_we && r) begin
      wr_addr_q.push_back(int'(bus.iram_addr));
      wr_data_q.push_back(bus.iram_wdata);
      last_wr_edge = cyc + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_encode(input cmd_t c);
    logic [31:0] w;
    w = 32'(c.op) * 32'h0400_0000;
    if (c.op == 6'h00)
      w = w + 32'(c.rs1) * 32'h20_0000 + 32'(c.rs2) * 32'h1_0000 + 32'(c.rd) * 32'h800
            + 32'(c.func);
    else if (c.op == 6'h02 || c.op == 6'h03)
      w = w + 32'(c.imm);
    else
      w = w + 32'(c.rs1) * 32'h20_0000 + 32'(c.rd) * 32'h1_0000 + (32'(c.imm) % 32'h1_0000);
    return w;
  endfunction

  function automatic cmd_t mk(input logic [5:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic [10:0] func,
                              input logic [25:0] imm, input logic last);
    cmd_t c;
    c.op = op; c.rs1 = rs1; c.rs2 = rs2; c.rd = rd; c.func = func; c.imm = imm; c.last = last;
    return c;
  endfunction

  function automatic logic [31:0] word_at(input int i);
    return (wr_data_q.size() > i) ? wr_data_q[i] : 32'hxxxx_xxxx;
  endfunction

  task automatic gen_prog(input int n, input bit with_last);
    prog_q.delete();
    for (int i = 0; i < n; i++) begin
      cmd_t c;
      case ($urandom_range(0, 3))
        0:       c.op = 6'h00;
        1:       c.op = 6'h02;
        2:       c.op = 6'h03;
        default: c.op = 6'($urandom);
      endcase
      c.rs1  = 5'($urandom);
      c.rs2  = 5'($urandom);
      c.rd   = 5'($urandom);
      c.func = 11'($urandom);
      c.imm  = 26'($urandom);
      c.last = with_last && (i == n - 1);
      prog_q.push_back(c);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    start = 1'b0;
    bus.cmd_valid = 1'b0;
    ready_mode = 0;
    repeat (2) @(negedge clk);
    wr_addr_q.delete();
    wr_data_q.delete();
    acc_q.delete();
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_prog(input bit gaps);
    foreach (prog_q[i]) begin
      int waited;
      waited = 0;
      if (err) break;
      if (gaps && $urandom_range(0, 2) == 0) begin
        bus.cmd_valid = 1'b0;
        @(negedge clk);
      end
      bus.cmd_valid  = 1'b1;
      bus.cmd_opcode = prog_q[i].op;
      bus.cmd_rs1    = prog_q[i].rs1;
      bus.cmd_rs2    = prog_q[i].rs2;
      bus.cmd_rd     = prog_q[i].rd;
      bus.cmd_func   = prog_q[i].func;
      bus.cmd_imm    = prog_q[i].imm;
      bus.cmd_last   = prog_q[i].last;
      while (!bus.cmd_ready && !err && waited < 300) begin
        @(negedge clk);
        waited++;
      end
      if (bus.cmd_ready) begin
        acc_q.push_back(prog_q[i]);
        @(negedge clk);
      end else begin
        if (!err) check("cmd_accept", 64'(bus.cmd_ready), 64'(1));
        break;
      end
    end
    bus.cmd_valid = 1'b0;
  endtask

  task automatic finish_prog(input string tag);
    int          waited, rise_cyc, n_wr;
    logic [31:0] exp_q[$];
    bit          has_last, exp_err, exp_done;
    waited = 0;
    while (!done && !err && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    rise_cyc = cyc;
    check({tag, ":finished"}, 64'(done | err), 64'(1));
    repeat (3) @(negedge clk);
    has_last = 1'b0;
    foreach (acc_q[i]) begin
      exp_q.push_back(ref_encode(acc_q[i]));
      if (acc_q[i].last) has_last = 1'b1;
    end
    if (has_last) for (int k = 0; k < int'(PADS); k++) exp_q.push_back(NOP);
    exp_err  = exp_q.size() > int'(DEPTH);
    exp_done = has_last && !exp_err;
    n_wr     = exp_err ? int'(DEPTH) : exp_q.size();
    check({tag, ":n_writes"}, 64'(wr_data_q.size()), 64'(n_wr));
    for (int i = 0; i < n_wr && i < wr_data_q.size(); i++) begin
      check({tag, ":addr"}, 64'(wr_addr_q[i]), 64'(i));
      check({tag, ":data"}, 64'(wr_data_q[i]), 64'(exp_q[i]));
    end
    check({tag, ":err"}, 64'(err), 64'(exp_err));
    check({tag, ":done"}, 64'(done), 64'(exp_done));
    check({tag, ":dlx_rst"}, 64'(dlx_rst), 64'(exp_done));
    check({tag, ":word_count"}, 64'(word_count), 64'(n_wr));
    check({tag, ":busy"}, 64'(busy), 64'(0));
    check({tag, ":iram_we"}, 64'(bus.iram_we), 64'(0));
    check({tag, ":cmd_ready"}, 64'(bus.cmd_ready), 64'(0));
    if (exp_done) begin
      check({tag, ":hold_gap"}, 64'(rise_cyc - last_wr_edge), 64'(HOLD));
      pulse_start();
      @(negedge clk);
      check({tag, ":start_ignored"}, 64'({done, busy, word_count}), 64'({1'b1, 1'b0, 4'(n_wr)}));
    end
  endtask

  initial begin
    int waited;
    rst = 1'b0;
    start = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_opcode = '0; bus.cmd_rs1 = '0; bus.cmd_rs2 = '0; bus.cmd_rd = '0;
    bus.cmd_func = '0; bus.cmd_imm = '0; bus.cmd_last = 1'b0;
    repeat (2) @(negedge clk);
    check("rst:iram_we", 64'(bus.iram_we), 64'(0));
    check("rst:cmd_ready", 64'(bus.cmd_ready), 64'(0));
    check("rst:status", 64'({dlx_rst, busy, done, err}), 64'(0));
    check("rst:word_count", 64'(word_count), 64'(0));

    do_reset();
    pulse_start();
    prog_q.delete();
    prog_q.push_back(mk(6'h00, 5'd1, 5'd2, 5'd3, 11'h020, 26'h0, 1'b1));
    send_prog(1'b0);
    finish_prog("add");
    check("add:word0", 64'(word_at(0)), 64'(32'h0022_1820));

    do_reset();
    pulse_start();
    prog_q.delete();
    prog_q.push_back(mk(6'h08, 5'd1, 5'd0, 5'd5, 11'h0, 26'h3FF_FFFF, 1'b1));
    send_prog(1'b0);
    finish_prog("addi");
    check("addi:word0", 64'(word_at(0)), 64'(32'h2025_FFFF));

    do_reset();
    pulse_start();
    prog_q.delete();
    prog_q.push_back(mk(6'h02, 5'd0, 5'd0, 5'd0, 11'h0, 26'h3FF_FFFF, 1'b1));
    send_prog(1'b0);
    finish_prog("j");
    check("j:word0", 64'(word_at(0)), 64'(32'h0BFF_FFFF));
    check("j:word2", 64'(word_at(2)), 64'(32'h5400_0000));

    // Stalled IRAM: five commands fit (four buffered plus one in the output register).
    do_reset();
    ready_mode = 2;
    gen_prog(6, 1'b1);
    pulse_start();
    fork
      send_prog(1'b0);
      begin
        repeat (12) @(negedge clk);
        check("bp:accepted", 64'(acc_q.size()), 64'(5));
        check("bp:cmd_ready", 64'(bus.cmd_ready), 64'(0));
        check("bp:iram_we", 64'(bus.iram_we), 64'(1));
        check("bp:iram_addr", 64'(bus.iram_addr), 64'(0));
        ready_mode = 1;
      end
    join
    finish_prog("bp");

    do_reset();
    gen_prog(9, 1'b0);
    pulse_start();
    send_prog(1'b0);
    finish_prog("overflow");

    // Asynchronous reset with a write pending.
    do_reset();
    ready_mode = 2;
    gen_prog(2, 1'b0);
    pulse_start();
    send_prog(1'b0);
    waited = 0;
    while (!bus.iram_we && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("mr:we_before", 64'(bus.iram_we), 64'(1));
    #2 rst = 1'b0;
    #1;
    check("mr:iram_we", 64'(bus.iram_we), 64'(0));
    check("mr:word_count", 64'(word_count), 64'(0));
    check("mr:status", 64'({dlx_rst, busy, done, err, bus.cmd_ready}), 64'(0));
    @(negedge clk);
    wr_addr_q.delete();
    wr_data_q.delete();
    acc_q.delete();
    ready_mode = 0;
    rst = 1'b1;
    @(negedge clk);
    check("mr:idle_busy", 64'(busy), 64'(0));
    gen_prog(3, 1'b1);
    pulse_start();
    send_prog(1'b1);
    finish_prog("after_rst");

    for (int t = 0; t < 10; t++) begin
      do_reset();
      ready_mode = int'($urandom_range(0, 1));
      gen_prog(int'($urandom_range(1, 8)), 1'b1);
      pulse_start();
      send_prog(1'b1);
      finish_prog("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached, got no summary expected summary");
    $fatal(1, "watchdog");
  end
endmodule
